// File: rtl/audio_stereo_router.sv
// Stereo ADC->DAC router: per-channel FIFOs, frame pairing, run-time routing mode.
// Optional level meter on the lights port when AUDIO_ROUTER_METER_EN is defined.
module audio_stereo_router #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int LIGHT_SHIFT = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] left_in_data,
  input  logic              left_in_valid,
  output logic              left_in_ready,
  input  logic [DATA_W-1:0] right_in_data,
  input  logic              right_in_valid,
  output logic              right_in_ready,
  output logic [DATA_W-1:0] left_out_data,
  output logic              left_out_valid,
  input  logic              left_out_ready,
  output logic [DATA_W-1:0] right_out_data,
  output logic              right_out_valid,
  input  logic              right_out_ready,
`ifdef AUDIO_ROUTER_METER_EN
  input  logic [1:0]        mode,
  output logic [9:0]        lights
`else
  input  logic [1:0]        mode
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      LIGHT_SHIFT < 1 || DATA_W < 9) begin : g_bad_param
    $error("audio_stereo_router: illegal parameter set");
  end

  logic [DATA_W-1:0] l_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       l_wp, l_rp, r_wp, r_rp;
  logic              l_full, r_full, l_empty, r_empty;
  logic              l_push, r_push, pop;
  logic [DATA_W-1:0] l_head, r_head;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] mix, nl, nr;
  logic              lv, rv;
  logic [DATA_W-1:0] ld, rd;

  assign l_full  = (l_wp[AW] != l_rp[AW]) &&
                   (l_wp[AW-1:0] == l_rp[AW-1:0]);
  assign r_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign l_empty = (l_wp == l_rp);
  assign r_empty = (r_wp == r_rp);

  assign left_in_ready  = !l_full && !reset;
  assign right_in_ready = !r_full && !reset;
  assign l_push = left_in_valid && left_in_ready;
  assign r_push = right_in_valid && right_in_ready;

  // A frame leaves only when both sides can take it, so L/R never skew.
  assign pop = !l_empty && !r_empty &&
               (!lv || left_out_ready) &&
               (!rv || right_out_ready);

  assign l_head = l_mem[l_rp[AW-1:0]];
  assign r_head = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (l_push) l_mem[l_wp[AW-1:0]] <= left_in_data;
    if (r_push) r_mem[r_wp[AW-1:0]] <= right_in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_wp <= '0;
      l_rp <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (l_push) l_wp <= l_wp + 1'b1;
      if (r_push) r_wp <= r_wp + 1'b1;
      if (pop) begin
        l_rp <= l_rp + 1'b1;
        r_rp <= r_rp + 1'b1;
      end
    end
  end

  // Sign-extended sum at DATA_W+1 bits; dropping bit 0 is the >>>1.
  assign sum = {l_head[DATA_W-1], l_head} +
               {r_head[DATA_W-1], r_head};
  assign mix = sum[DATA_W:1];

  always_comb begin
    nl = l_head;
    nr = r_head;
    unique case (mode)
      2'b00: begin
        nl = l_head;
        nr = r_head;
      end
      2'b01: begin
        nl = l_head;
        nr = l_head;
      end
      2'b10: begin
        nl = r_head;
        nr = l_head;
      end
      2'b11: begin
        nl = mix;
        nr = mix;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lv <= 1'b0;
      rv <= 1'b0;
      ld <= '0;
      rd <= '0;
    end else begin
      if (pop) begin
        lv <= 1'b1;
        ld <= nl;
      end else if (left_out_ready) begin
        lv <= 1'b0;
      end
      if (pop) begin
        rv <= 1'b1;
        rd <= nr;
      end else if (right_out_ready) begin
        rv <= 1'b0;
      end
    end
  end

  assign left_out_valid  = lv;
  assign left_out_data   = ld;
  assign right_out_valid = rv;
  assign right_out_data  = rd;

`ifdef AUDIO_ROUTER_METER_EN
  logic [DATA_W-1:0]      mag;
  logic [7:0]             level, peak, therm;
  logic [LIGHT_SHIFT-1:0] dcnt;
  logic                   tog;

  // Most negative sample has no positive twin; clamp it to full scale.
  always_comb begin
    mag = ld;
    if (ld[DATA_W-1]) begin
      if (ld == {1'b1, {(DATA_W-1){1'b0}}})
        mag = {1'b0, {(DATA_W-1){1'b1}}};
      else
        mag = -ld;
    end
  end

  assign level = mag[DATA_W-2 -: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      peak <= '0;
      dcnt <= '0;
      tog  <= 1'b0;
    end else begin
      dcnt <= dcnt + 1'b1;
      tog  <= tog ^ pop;
      if (lv && left_out_ready && level > peak)
        peak <= level;
      else if ((&dcnt) && peak != 8'd0)
        peak <= peak - 8'd1;
    end
  end

  always_comb begin
    therm = '0;
    for (int i = 0; i < 8; i++)
      therm[i] = |(peak >> i);
  end

  assign lights = {tog,
                   left_in_valid && !left_in_ready && !reset,
                   therm};
`endif

endmodule
